// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter
// Round-robin arbiter and sequencer that lends one external WIDTH-bit D
// register to N_REQ requesters. Each transaction is two cycles: a WRITE cycle
// that drives the register's d/enable, then an ACK cycle that returns the
// captured Q to the owner. With lock held, an owner may keep the register for
// up to HOLD_MAX back-to-back transactions before it must release it.
module dff_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       rdata,
  output logic [WIDTH-1:0]       reg_d,
  output logic                   reg_en,
  input  logic [WIDTH-1:0]       reg_q,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [IDX_W-1:0] owner_next_ptr;
  logic [IDX_W-1:0] win_idle;
  logic [IDX_W-1:0] win_ack;
  logic [WIDTH-1:0] wdata_arr [N_REQ];

  // First requester at or after 'start', wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             found;
    int               j;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(start) + i;
      if (j >= N_REQ) j = j - N_REQ;
      idx = IDX_W'(j);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Index after i, wrapping modulo N_REQ (N_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Candidate winners and the datapath mux onto the shared register.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    owner_next_ptr = next_idx(owner);
    win_idle       = rr_pick(req, ptr);
    win_ack        = rr_pick(req, owner_next_ptr);
    for (int i = 0; i < N_REQ; i++) wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
    reg_en = (state == WRITE) && req[owner];
    reg_d  = reg_en ? wdata_arr[owner] : '0;
    rdata  = (state == ACK) ? reg_q : '0;
    busy   = (state != IDLE);
  end

  // Sequencer: arbitration, ownership, lock bursts and the registered gnt/ack.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register updates from
    // the same pre-edge values regardless of statement order.
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      ack      <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            owner    <= win_idle;
            gnt      <= to_onehot(win_idle);
            hold_cnt <= CNT_W'(1);
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (req[owner]) begin
            ack   <= gnt;
            state <= ACK;
          end else begin
            // Owner withdrew before its write: drop it without an ack.
            ptr      <= owner_next_ptr;
            gnt      <= '0;
            hold_cnt <= '0;
            state    <= IDLE;
          end
        end
        ACK: begin
          if (lock[owner] && req[owner] && (hold_cnt < CNT_W'(HOLD_MAX))) begin
            hold_cnt <= hold_cnt + 1'b1;
            state    <= WRITE;
          end else begin
            // Release: priority moves past the old owner, re-arbitrate now so
            // there is no idle bubble between owners.
            ptr <= owner_next_ptr;
            if (|req) begin
              owner    <= win_ack;
              gnt      <= to_onehot(win_ack);
              hold_cnt <= CNT_W'(1);
              state    <= WRITE;
            end else begin
              gnt      <= '0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// transaction-level model of the arbitration rules.
module tb_dff_share_arbiter;

  localparam int N_REQ      = 4;
  localparam int WIDTH      = 8;
  localparam int HOLD_MAX   = 4;
  localparam int WAIT_BOUND = 2 * HOLD_MAX * N_REQ + 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       rdata;
  logic [WIDTH-1:0]       reg_d;
  logic                   reg_en;
  logic [WIDTH-1:0]       reg_q = '0;
  logic                   busy;

  int checks   = 0;
  int failures = 0;

  dff_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .reg_d(reg_d), .reg_en(reg_en),
    .reg_q(reg_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // The shared D register the arbiter controls.
  always @(posedge clk) if (reg_en) reg_q <= reg_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int               owner;   // -1 when nobody owns the register
    bit               acking;  // owner's write done, this cycle returns Q
    int               burst;   // transactions in the current ownership
    int               ptr;     // highest-priority requester
    logic [WIDTH-1:0] written; // value the register captured for the owner
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.owner = -1; r.acking = 1'b0; r.burst = 0; r.ptr = 0; r.written = '0;
    return r;
  endfunction

  function automatic int first_from(input logic [N_REQ-1:0] r, input int start);
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (start + k) % N_REQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic model_t model_step(input model_t s, input logic [N_REQ-1:0] r,
                                        input logic [N_REQ-1:0] l,
                                        input logic [N_REQ*WIDTH-1:0] d);
    model_t n;
    n = s;
    if (s.owner < 0) begin
      n.owner  = first_from(r, s.ptr);
      n.burst  = (n.owner >= 0) ? 1 : 0;
      n.acking = 1'b0;
    end else if (!s.acking) begin
      if (r[s.owner]) begin
        n.acking  = 1'b1;
        n.written = d[s.owner*WIDTH +: WIDTH];
      end else begin
        n.ptr   = (s.owner + 1) % N_REQ;
        n.owner = -1;
      end
    end else begin
      n.acking = 1'b0;
      if (l[s.owner] && r[s.owner] && s.burst < HOLD_MAX) begin
        n.burst = s.burst + 1;
      end else begin
        n.ptr   = (s.owner + 1) % N_REQ;
        n.owner = first_from(r, n.ptr);
        n.burst = (n.owner >= 0) ? 1 : 0;
      end
    end
    return n;
  endfunction

  initial begin
    m = model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m = model_reset();
      else        m = model_step(m, req, lock, wdata);
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic [N_REQ-1:0] e_gnt, e_ack;
  logic [WIDTH-1:0] e_d, e_rdata;
  logic             e_en;
  int               wait_cnt [N_REQ];
  int               max_wait [N_REQ];

  initial begin
    for (int i = 0; i < N_REQ; i++) begin wait_cnt[i] = 0; max_wait[i] = 0; end
    forever begin
      @(negedge clk);
      #2;
      e_gnt = '0; e_ack = '0; e_en = 1'b0; e_d = '0; e_rdata = '0;
      if (m.owner >= 0) begin
        e_gnt[m.owner] = 1'b1;
        if (m.acking) begin
          e_ack[m.owner] = 1'b1;
          e_rdata        = m.written;
        end else if (req[m.owner]) begin
          e_en = 1'b1;
          e_d  = wdata[m.owner*WIDTH +: WIDTH];
        end
      end
      check("cyc_gnt",    gnt,    e_gnt);
      check("cyc_ack",    ack,    e_ack);
      check("cyc_reg_en", reg_en, e_en);
      check("cyc_reg_d",  reg_d,  e_d);
      check("cyc_rdata",  rdata,  e_rdata);
      check("cyc_busy",   busy,   m.owner >= 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (rst_n && req[i] && !(m.acking && m.owner == i)) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int idx_of(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; lock = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nack, last, t3, n;
    rst_n = 1'b0; req = '0; lock = '0; wdata = '0;

    // Reset holds everything idle even with all requests high.
    req = 4'b1111;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_reg_en", reg_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_first_gnt", gnt, 4'b0001);

    // Single write by requester 2.
    do_reset();
    wdata[2*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b0100;
    @(negedge clk); #1;
    check("single_gnt", gnt, 4'b0100);
    check("single_reg_en", reg_en, 1'b1);
    check("single_reg_d", reg_d, 8'hA5);
    @(negedge clk); #1;
    check("single_ack", ack, 4'b0100);
    check("single_rdata", rdata, 8'hA5);
    req = '0;
    @(negedge clk); #1;
    check("single_ack_gone", ack, 4'b0000);
    check("single_idle", busy, 1'b0);

    // Round robin with everyone requesting.
    do_reset();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b1111;
    nack = 0; last = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk); #1;
      if (ack != '0 && nack < 5) begin
        check("rr_owner", idx_of(ack), nack % 4);
        check("rr_rdata", rdata, 8'h11 * (idx_of(ack) + 1));
        if (nack > 0) check("rr_spacing", c - last, 2);
        last = c;
        nack++;
      end
    end
    check("rr_count", nack, 5);

    // Lock burst: requester 1 keeps the register for HOLD_MAX transactions.
    do_reset();
    wdata[1*WIDTH +: WIDTH] = 8'h5A;
    wdata[3*WIDTH +: WIDTH] = 8'hC3;
    req  = 4'b1010;
    lock = 4'b0010;
    t3 = -1; n = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      if (c == 9) check("lock_gnt_after_burst", gnt, 4'b1000);
      if (ack != '0 && n < 5) begin
        check("lock_seq", idx_of(ack), (n < 4) ? 1 : 3);
        if (ack[3] && t3 < 0) t3 = c;
        n++;
      end
    end
    check("lock_req3_ack_cycle", t3, 10);

    // Abort: requester 0 withdraws during its WRITE cycle.
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    req = 4'b1010;
    #1;
    check("abort_gnt_write", gnt, 4'b0001);
    check("abort_reg_en", reg_en, 1'b0);
    check("abort_ack", ack, 4'b0000);
    @(negedge clk);
    req = 4'b1011;
    #1;
    check("abort_idle_gnt", gnt, 4'b0000);
    check("abort_idle_busy", busy, 1'b0);
    check("abort_no_ack", ack, 4'b0000);
    @(negedge clk); #1;
    check("abort_next_gnt", gnt, 4'b0010);

    // Asynchronous reset in the middle of a WRITE.
    do_reset();
    wdata[0 +: WIDTH] = 8'h3C;
    req = 4'b0001;
    @(negedge clk); #1;
    check("midrst_reg_en_before", reg_en, 1'b1);
    check("midrst_reg_d_before", reg_d, 8'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_reg_en", reg_en, 1'b0);
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_busy", busy, 1'b0);
    req = 4'b1000;
    repeat (2) begin
      @(negedge clk); #1;
      check("midrst_no_ack", ack, 4'b0000);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("midrst_regrant", gnt, 4'b1000);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (m.owner == i && m.acking) begin
          if ($urandom_range(1, 0) == 0) begin
            req[i] = 1'b0;
          end else begin
            wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            lock[i] = ($urandom_range(1, 0) == 1);
          end
        end else if (m.owner == i) begin
          if ($urandom_range(31, 0) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
          wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          lock[i] = ($urandom_range(1, 0) == 1);
        end
      end
    end
    req = '0; lock = '0;
    repeat (10) @(negedge clk);
    #3;
    for (int i = 0; i < N_REQ; i++) check("starvation_bound", max_wait[i] <= WAIT_BOUND, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
